// File: rtl/spi_display_receiver.sv
// SPI slave model of the 7-segment display driver: synchronises sck/cs/mosi,
// assembles 16-bit MSB-first frames, commits them on CS release to a driver
// register file and exposes the registers plus a Code-B segment decoder.
// Ports: clk, res (sync, active-high), sck/cs/mosi (SPI pins),
//   word_valid/frame_err (commit pulses), word_out (last good frame),
//   dev_on, disp_test, decode_mode, intensity, scan_limit (control regs),
//   rd_digit (digit select), rd_raw/rd_seg (combinational digit read-out).
`timescale 1ns/1ps
module spi_display_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 16
) (
   input  logic        clk,
   input  logic        res,
   input  logic        sck,
   input  logic        cs,
   input  logic        mosi,
   output logic        word_valid,
   output logic        frame_err,
   output logic [15:0] word_out,
   output logic        dev_on,
   output logic        disp_test,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   input  logic [2:0]  rd_digit,
   output logic [7:0]  rd_raw,
   output logic [7:0]  rd_seg
);

   localparam int CW = $clog2(FRAME_BITS + 2);

   logic [SYNC_STAGES-1:0] r_sck_s;
   logic [SYNC_STAGES-1:0] r_cs_s;
   logic [SYNC_STAGES-1:0] r_mosi_s;
   logic                   r_sck_d;
   logic                   r_cs_d;
   logic [15:0]            r_shift;
   logic [CW-1:0]          r_cnt;
   logic                   r_valid;
   logic                   r_err;
   logic [15:0]            r_word;
   logic                   r_on;
   logic                   r_test;
   logic [7:0]             r_dec;
   logic [3:0]             r_int;
   logic [2:0]             r_scan;
   logic [7:0]             r_digit [0:7];

   logic          w_sck;
   logic          w_cs;
   logic          w_mosi;
   logic          w_sck_rise;
   logic          w_cs_rise;
   logic          w_cs_fall;
   logic          w_shift_en;
   logic [CW-1:0] w_cnt_base;
   logic [CW-1:0] w_cnt_new;
   logic [15:0]   w_shift_new;
   logic [3:0]    w_addr;
   logic [7:0]    w_data;
   logic [2:0]    w_didx;
   logic [6:0]    w_seg;

   assign w_sck  = r_sck_s[SYNC_STAGES-1];
   assign w_cs   = r_cs_s[SYNC_STAGES-1];
   assign w_mosi = r_mosi_s[SYNC_STAGES-1];

   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_cs_rise  = w_cs & ~r_cs_d;
   assign w_cs_fall  = ~w_cs & r_cs_d;

   // A bit arriving together with the cs release still belongs to the frame.
   assign w_shift_en = w_sck_rise & (~w_cs | w_cs_rise);
   assign w_cnt_base = w_cs_fall ? '0 : r_cnt;

   always_comb begin
      w_cnt_new = w_cnt_base;
      if (w_shift_en && w_cnt_base != CW'(FRAME_BITS + 1))
         w_cnt_new = w_cnt_base + 1'b1;
   end

   assign w_shift_new = w_shift_en ? {r_shift[14:0], w_mosi} : r_shift;
   assign w_addr      = w_shift_new[11:8];
   assign w_data      = w_shift_new[7:0];
   assign w_didx      = w_addr[2:0] - 3'd1;

   always_ff @(posedge clk) begin
      if (res) begin
         r_sck_s  <= '0;
         r_cs_s   <= '1;
         r_mosi_s <= '0;
         r_sck_d  <= 1'b0;
         r_cs_d   <= 1'b1;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_word   <= '0;
         r_on     <= 1'b0;
         r_test   <= 1'b0;
         r_dec    <= '0;
         r_int    <= '0;
         r_scan   <= '0;
         for (int i = 0; i < 8; i++) r_digit[i] <= '0;
      end else begin
         r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], sck};
         r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], cs};
         r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi};
         r_sck_d  <= w_sck;
         r_cs_d   <= w_cs;
         r_shift  <= w_shift_new;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         if (w_cs_rise) begin
            r_cnt <= '0;
            if (w_cnt_new == CW'(FRAME_BITS)) begin
               r_valid <= 1'b1;
               r_word  <= w_shift_new;
               case (w_addr)
                  4'h0, 4'hD, 4'hE: ;
                  4'h9: r_dec  <= w_data;
                  4'hA: r_int  <= w_data[3:0];
                  4'hB: r_scan <= w_data[2:0];
                  4'hC: r_on   <= w_data[0];
                  4'hF: r_test <= w_data[0];
                  default: r_digit[w_didx] <= w_data;
               endcase
            end else begin
               r_err <= 1'b1;
            end
         end else begin
            r_cnt <= w_cnt_new;
         end
      end
   end

   assign word_valid  = r_valid;
   assign frame_err   = r_err;
   assign word_out    = r_word;
   assign dev_on      = r_on;
   assign disp_test   = r_test;
   assign decode_mode = r_dec;
   assign intensity   = r_int;
   assign scan_limit  = r_scan;
   assign rd_raw      = r_digit[rd_digit];

   // Segment bits {a,b,c,d,e,f,g}.
   always_comb begin
      w_seg = 7'h00;
      case (rd_raw[3:0])
         4'h0: w_seg = 7'h7E;
         4'h1: w_seg = 7'h30;
         4'h2: w_seg = 7'h6D;
         4'h3: w_seg = 7'h79;
         4'h4: w_seg = 7'h33;
         4'h5: w_seg = 7'h5B;
         4'h6: w_seg = 7'h5F;
         4'h7: w_seg = 7'h70;
         4'h8: w_seg = 7'h7F;
         4'h9: w_seg = 7'h7B;
         4'hA: w_seg = 7'h01;
         4'hB: w_seg = 7'h4F;
         4'hC: w_seg = 7'h37;
         4'hD: w_seg = 7'h0E;
         4'hE: w_seg = 7'h67;
         default: w_seg = 7'h00;
      endcase
   end

   assign rd_seg = decode_mode[rd_digit] ? {rd_raw[7], w_seg} : rd_raw;

endmodule

// File: tb/tb_spi_display_receiver.sv
// Self-checking bench for spi_display_receiver: directed scenarios followed
// by random frames, compared against a register-map model of the driver.
`timescale 1ns/1ps
module tb_spi_display_receiver;

   logic        clk = 1'b0;
   logic        res;
   logic        sck;
   logic        cs;
   logic        mosi;
   logic        word_valid;
   logic        frame_err;
   logic [15:0] word_out;
   logic        dev_on;
   logic        disp_test;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic [2:0]  rd_digit;
   logic [7:0]  rd_raw;
   logic [7:0]  rd_seg;

   spi_display_receiver dut (
      .clk(clk), .res(res), .sck(sck), .cs(cs), .mosi(mosi),
      .word_valid(word_valid), .frame_err(frame_err),
      .word_out(word_out), .dev_on(dev_on), .disp_test(disp_test),
      .decode_mode(decode_mode), .intensity(intensity),
      .scan_limit(scan_limit), .rd_digit(rd_digit),
      .rd_raw(rd_raw), .rd_seg(rd_seg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_err   = 0;

   always @(negedge clk) begin
      if (word_valid) n_valid++;
      if (frame_err)  n_err++;
   end

   // reference model
   logic [15:0] m_word;
   logic        m_on;
   logic        m_test;
   logic [7:0]  m_dec;
   logic [3:0]  m_int;
   logic [2:0]  m_scan;
   logic [7:0]  m_dig [8];
   int          m_valid = 0;
   int          m_err   = 0;

   // lit segments of each Code-B character
   string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "g", "adefg",
                        "bcefg", "def", "abefg", ""};

   function automatic logic [6:0] seg_bits(string s);
      logic [6:0] b = '0;
      for (int i = 0; i < s.len(); i++) b[6 - (int'(s[i]) - 97)] = 1'b1;
      return b;
   endfunction

   function automatic logic [7:0] exp_seg(int d);
      logic [7:0] raw = m_dig[d];
      if (m_dec[d]) return {raw[7], seg_bits(segs[raw[3:0]])};
      return raw;
   endfunction

   task automatic model_reset();
      m_word = '0; m_on = 0; m_test = 0; m_dec = '0;
      m_int = '0; m_scan = '0;
      for (int i = 0; i < 8; i++) m_dig[i] = '0;
   endtask

   task automatic model_apply(logic [15:0] v, int n);
      int a;
      if (n != 16) begin
         m_err++;
         return;
      end
      m_valid++;
      m_word = v;
      a = int'(v[11:8]);
      if (a >= 1 && a <= 8) m_dig[a-1] = v[7:0];
      else if (a == 9)  m_dec  = v[7:0];
      else if (a == 10) m_int  = v[3:0];
      else if (a == 11) m_scan = v[2:0];
      else if (a == 12) m_on   = v[0];
      else if (a == 15) m_test = v[0];
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ":nvalid"}, n_valid, m_valid);
      chk({tag, ":nerr"}, n_err, m_err);
      chk({tag, ":word"}, word_out, m_word);
      chk({tag, ":on"}, dev_on, m_on);
      chk({tag, ":test"}, disp_test, m_test);
      chk({tag, ":dec"}, decode_mode, m_dec);
      chk({tag, ":int"}, intensity, m_int);
      chk({tag, ":scan"}, scan_limit, m_scan);
      for (int d = 0; d < 8; d++) begin
         rd_digit = 3'(d);
         #1;
         chk($sformatf("%s:raw%0d", tag, d), rd_raw, m_dig[d]);
         chk($sformatf("%s:seg%0d", tag, d), rd_seg, exp_seg(d));
      end
   endtask

   task automatic shift_bits(logic [31:0] v, int n);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = v[i];
         repeat (2) @(negedge clk);
         sck = 1'b1;
         repeat (2) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   task automatic send(logic [31:0] v, int n);
      @(negedge clk);
      cs = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(v, n);
      repeat (2) @(negedge clk);
      cs = 1'b1;
      model_apply(v[15:0], n);
      repeat (16) @(negedge clk);
   endtask

   initial begin
      logic [31:0] v;
      int n;
      int r;
      int b0;
      int lens [5] = '{14, 15, 17, 18, 20};

      res = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; rd_digit = '0;
      repeat (3) @(negedge clk);
      res = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst:valid", word_valid, 1'b0);
      chk("rst:err", frame_err, 1'b0);
      check_all("rst");

      send(32'h0C01, 16);
      send(32'h09FF, 16);
      chk("on1", dev_on, 1'b1);
      chk("decff", decode_mode, 8'hFF);
      chk("two_pulses", n_valid, 2);
      check_all("init");

      send(32'h0185, 16);
      rd_digit = 3'd0;
      #1;
      chk("d0raw", rd_raw, 8'h85);
      chk("d0seg", rd_seg, 8'hDB);

      send(32'h0900, 16);
      send(32'h0385, 16);
      rd_digit = 3'd2;
      #1;
      chk("d2pass", rd_seg, 8'h85);
      check_all("pass");

      send(32'h0A07, 15);
      check_all("short15");
      send(32'h0B0A5, 17);
      check_all("long17");

      // reset in the middle of a frame
      @(negedge clk);
      cs = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(32'h0A, 8);
      b0 = n_valid + n_err;
      res = 1'b1; cs = 1'b1; sck = 1'b0;
      repeat (3) @(negedge clk);
      res = 1'b0;
      model_reset();
      repeat (8) @(negedge clk);
      chk("rst_nopulse", n_valid + n_err, b0);
      send(32'h0A03, 16);
      chk("int3", intensity, 4'h3);
      check_all("midrst");

      // six back-to-back digit frames
      for (int i = 0; i < 6; i++) begin
         v = {16'h0, 8'(i + 1), 8'($urandom)};
         send(v, 16);
      end
      check_all("six");

      for (int k = 0; k < 40; k++) begin
         v = $urandom;
         r = $urandom_range(0, 9);
         n = (r < 7) ? 16 : lens[$urandom_range(0, 4)];
         send(v, n);
         check_all($sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
